// File: rtl/seq_det_pkg.sv
// Shared state encoding and default parameters for the serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int         SEQ_W       = 6;
  localparam logic [5:0] SEQ_PAT_DEF = 6'b101011;
  localparam int         SEQ_CW      = 8;

endpackage

// File: rtl/seq_shift_win.sv
// W-bit serial window: newest bit enters the LSB; clear beats shift.
module seq_shift_win #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         r,
  input  logic         en,
  input  logic         clr,
  input  logic         d,
  output logic [W-1:0] win,
  output logic [W-1:0] nxt
);

  assign nxt = {win[W-2:0], d};

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      win <= '0;
    end else if (clr) begin
      win <= '0;
    end else if (en) begin
      win <= nxt;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run controller for a serial pattern detector: arm, fill, count matches to a target.
// Define SEQ_NOOVERLAP_EN to restart the fill after every match instead of overlapping.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int           W       = SEQ_W,
  parameter logic [W-1:0] PAT_DEF = W'(SEQ_PAT_DEF),
  parameter int           CW      = SEQ_CW
) (
  input  logic          clk,
  input  logic          r,
  input  logic          cfg_we,
  input  logic [W-1:0]  cfg_pat,
  input  logic [CW-1:0] cfg_cnt,
  input  logic          start,
  input  logic          abort,
  input  logic          d,
  output logic          busy,
  output logic          done,
  output logic          flag,
  output logic [CW-1:0] match_cnt,
  output logic [W-1:0]  pat
);

  localparam int FW = $clog2(W);

  state_e        state;
  logic [FW-1:0] fill;
  logic [CW-1:0] target;
  logic [W-1:0]  win;
  logic [W-1:0]  nxt;
  logic          last_fill;
  logic          hit;
  logic          hit_done;
  logic          run_go;
  logic          sh_en;
  logic          sh_clr;
  logic          unused_win;

  assign busy      = (state == FILL) || (state == RUN);
  assign done      = (state == DONE);
  assign last_fill = (fill == FW'(W - 1));
  // Only a completely filled window may be compared against the pattern.
  assign hit       = (nxt == pat) && ((state == RUN) || ((state == FILL) && last_fill));
  assign hit_done  = (target != '0) &&
                     (({1'b0, match_cnt} + (CW+1)'(1)) == {1'b0, target});
  assign run_go    = start && !abort && ((state == IDLE) || (state == DONE));
  assign sh_en     = busy && !abort;
`ifdef SEQ_NOOVERLAP_EN
  assign sh_clr    = run_go || (hit && !abort);
`else
  assign sh_clr    = run_go;
`endif
  assign unused_win = ^win;

  seq_shift_win #(.W(W)) u_win (
    .clk (clk),
    .r   (r),
    .en  (sh_en),
    .clr (sh_clr),
    .d   (d),
    .win (win),
    .nxt (nxt)
  );

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state     <= IDLE;
      fill      <= '0;
      match_cnt <= '0;
      flag      <= 1'b0;
      pat       <= PAT_DEF;
      target    <= '0;
    end else begin
      flag <= 1'b0;
      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (cfg_we) begin
              pat    <= cfg_pat;
              target <= cfg_cnt;
            end
            if (start) begin
              fill      <= '0;
              match_cnt <= '0;
              state     <= FILL;
            end
          end
          FILL: begin
            fill <= fill + FW'(1);
            if (last_fill) state <= RUN;
          end
          RUN: ;
          default: state <= IDLE;
        endcase
        if (hit) begin
          flag <= 1'b1;
          if (match_cnt != '1) match_cnt <= match_cnt + CW'(1);
          if (hit_done) begin
            state <= DONE;
          end
`ifdef SEQ_NOOVERLAP_EN
          else begin
            state <= FILL;
            fill  <= '0;
          end
`endif
        end
      end
    end
  end

endmodule
